// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, FSM states, error codes and SECDED encoder
package hamming_pkg;

  localparam int DW = 11;
  localparam int CW = 16;
  localparam int AW = 4;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    HOST_WR,
    HOST_RD,
    SCRUB_RD,
    WRITEBACK
  } state_t;

  // Extended Hamming (16,11): data in non-power-of-two positions, bit 0 is overall parity.
  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    c        = '0;
    c[3]     = d[0];
    c[7:5]   = d[3:1];
    c[15:9]  = d[10:4];
    c[1]     = ^{c[3], c[5], c[7], c[9], c[11], c[13], c[15]};
    c[2]     = ^{c[3], c[6], c[7], c[10], c[11], c[14], c[15]};
    c[4]     = ^{c[7:5], c[15:12]};
    c[8]     = ^c[15:9];
    c[0]     = ^c[15:1];
    return c;
  endfunction

  // Pull the 11 data bits back out of a codeword.
  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_if.sv
// rtl/hamming_scrub_ctrl_if.sv - host request/response bundle for the scrub controller
interface hamming_scrub_ctrl_if;
  import hamming_pkg::*;

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] inject_mask;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          scrub_en;
  logic          host_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_err;
  logic [7:0]    corr_count;
  logic [7:0]    uncorr_count;

  modport master (
    output wr_req, wr_addr, wr_data, inject_mask, rd_req, rd_addr, scrub_en,
    input  host_ready, rd_valid, rd_data, rd_err, corr_count, uncorr_count
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, inject_mask, rd_req, rd_addr, scrub_en,
    output host_ready, rd_valid, rd_data, rd_err, corr_count, uncorr_count
  );

endinterface

// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - combinational SECDED decode and single-bit correction
module hamming_secded_dec
  import hamming_pkg::*;
(
  input  logic [CW-1:0] code,
  output logic [DW-1:0] data,
  output logic [CW-1:0] corrected,
  output logic [1:0]    err
);

  logic [3:0] syn;
  logic       parity_bad;

  // Syndrome is the XOR of indices of all set bits; overall parity separates single from double errors.
  always_comb begin
    syn        = '0;
    parity_bad = ^code;
    corrected  = code;
    err        = ERR_NONE;
    for (int i = 1; i < CW; i++) begin
      if (code[i]) syn = syn ^ 4'(i);
    end
    if (parity_bad) begin
      corrected[syn] = ~code[syn];
      err            = ERR_CORR;
    end else if (syn != 4'd0) begin
      err = ERR_UNCORR;
    end
    data = extract(corrected);
  end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// rtl/hamming_scrub_ctrl.sv - SECDED-protected 16-entry store with host access and background scrub
module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter int SCRUB_INTERVAL = 1024,
  parameter int DEPTH          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_scrub_ctrl_if.slave  bus
);

  localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  state_t        state, next_state;
  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] op_addr;
  logic [CW-1:0] op_code;
  logic [AW-1:0] scrub_ptr;
  logic [TW-1:0] timer;
  logic          scrub_pending;
  logic [DW-1:0] dec_data;
  logic [CW-1:0] dec_code;
  logic [1:0]    dec_err;
  logic          enter_scrub;
  logic          timer_fire;

  hamming_secded_dec u_dec (
    .code      (mem[op_addr]),
    .data      (dec_data),
    .corrected (dec_code),
    .err       (dec_err)
  );

  assign bus.host_ready = (state == IDLE);
  assign enter_scrub    = (state == IDLE) && (next_state == SCRUB_RD);
  assign timer_fire     = bus.scrub_en && (timer == TW'(SCRUB_INTERVAL - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: writes beat reads beat scrubs; only corrected reads need a writeback.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.wr_req)         next_state = HOST_WR;
        else if (bus.rd_req)    next_state = HOST_RD;
        else if (scrub_pending) next_state = SCRUB_RD;
      end
      HOST_WR:             next_state = IDLE;
      HOST_RD, SCRUB_RD:   next_state = (dec_err == ERR_CORR) ? WRITEBACK : IDLE;
      WRITEBACK:           next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // Operand capture at acceptance and array updates; the array only changes in HOST_WR or WRITEBACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      op_addr <= '0;
      op_code <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.wr_req) begin
          op_addr <= bus.wr_addr;
          op_code <= encode(bus.wr_data) ^ bus.inject_mask;
        end else if (bus.rd_req) begin
          op_addr <= bus.rd_addr;
        end else if (scrub_pending) begin
          op_addr <= scrub_ptr;
        end
      end
      if (state == HOST_WR)   mem[op_addr] <= op_code;
      if (state == WRITEBACK) mem[op_addr] <= dec_code;
    end
  end

  // Scrub interval timer, pending flag and address pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer         <= '0;
      scrub_pending <= 1'b0;
      scrub_ptr     <= '0;
    end else begin
      if (bus.scrub_en) timer <= timer_fire ? '0 : timer + 1'b1;
      if (enter_scrub)     scrub_pending <= 1'b0;
      else if (timer_fire) scrub_pending <= 1'b1;
      if (state == SCRUB_RD) scrub_ptr <= scrub_ptr + 1'b1;
    end
  end

  // Host read response strobe and saturating error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid     <= 1'b0;
      bus.rd_data      <= '0;
      bus.rd_err       <= ERR_NONE;
      bus.corr_count   <= '0;
      bus.uncorr_count <= '0;
    end else begin
      bus.rd_valid <= (state == HOST_RD);
      if (state == HOST_RD) begin
        bus.rd_data <= dec_data;
        bus.rd_err  <= dec_err;
      end
      if (state == HOST_RD || state == SCRUB_RD) begin
        if (dec_err == ERR_CORR && bus.corr_count != 8'hFF)
          bus.corr_count <= bus.corr_count + 1'b1;
        if (dec_err == ERR_UNCORR && bus.uncorr_count != 8'hFF)
          bus.uncorr_count <= bus.uncorr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// tb/tb_hamming_scrub_ctrl.sv - directed checks for hamming_scrub_ctrl
module tb_hamming_scrub_ctrl;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hamming_scrub_ctrl_if bus ();

  hamming_scrub_ctrl #(.SCRUB_INTERVAL(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic do_reset();
    rst             = 1'b1;
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.inject_mask = '0;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = '0;
    bus.scrub_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready(input string what);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.host_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout host_ready=%0b required=1", what, bus.host_ready);
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [10:0] d, input logic [15:0] m);
    bus.wr_addr     = a;
    bus.wr_data     = d;
    bus.inject_mask = m;
    bus.wr_req      = 1'b1;
    wait_ready("write");
    @(posedge clk);
    #1 bus.wr_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [10:0] d, output logic [1:0] e,
                           output logic v1, output logic v2);
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    wait_ready("read");
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    v1 = bus.rd_valid;
    d  = bus.rd_data;
    e  = bus.rd_err;
    @(posedge clk);
    #1;
    v2 = bus.rd_valid;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.host_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.host_ready); end
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    if (bus.rd_data !== 11'h000) begin failures++; $display("FAIL reset_rd_data got=%h exp=000", bus.rd_data); end
    if (bus.rd_err !== 2'b00) begin failures++; $display("FAIL reset_rd_err got=%b exp=00", bus.rd_err); end
    if (bus.corr_count !== 8'd0) begin failures++; $display("FAIL reset_corr got=%0d exp=0", bus.corr_count); end
    if (bus.uncorr_count !== 8'd0) begin failures++; $display("FAIL reset_uncorr got=%0d exp=0", bus.uncorr_count); end
  endtask

  task automatic test_write_read();
    logic [10:0] d; logic [1:0] e; logic v1, v2;
    do_reset();
    host_write(4'd3, 11'h001, 16'h0000);
    checks++;
    if (dut.mem[3] !== 16'h000F) begin failures++; $display("FAIL wr_codeword got=%h exp=000F", dut.mem[3]); end
    host_read(4'd3, d, e, v1, v2);
    checks += 4;
    if (v1 !== 1'b1) begin failures++; $display("FAIL rd_valid_pulse got=%b exp=1", v1); end
    if (v2 !== 1'b0) begin failures++; $display("FAIL rd_valid_one_cycle got=%b exp=0", v2); end
    if (d !== 11'h001) begin failures++; $display("FAIL rd_data_clean got=%h exp=001", d); end
    if (e !== 2'b00) begin failures++; $display("FAIL rd_err_clean got=%b exp=00", e); end
  endtask

  task automatic test_single_error();
    logic [10:0] d; logic [1:0] e; logic v1, v2;
    do_reset();
    host_write(4'd0, 11'h001, 16'h0010);
    host_read(4'd0, d, e, v1, v2);
    checks += 5;
    if (d !== 11'h001) begin failures++; $display("FAIL sbe_data got=%h exp=001", d); end
    if (e !== 2'b01) begin failures++; $display("FAIL sbe_err got=%b exp=01", e); end
    if (bus.corr_count !== 8'd1) begin failures++; $display("FAIL sbe_corr got=%0d exp=1", bus.corr_count); end
    if (bus.uncorr_count !== 8'd0) begin failures++; $display("FAIL sbe_uncorr got=%0d exp=0", bus.uncorr_count); end
    if (dut.mem[0] !== 16'h000F) begin failures++; $display("FAIL sbe_writeback got=%h exp=000F", dut.mem[0]); end
    host_read(4'd0, d, e, v1, v2);
    checks += 2;
    if (e !== 2'b00) begin failures++; $display("FAIL sbe_reread_err got=%b exp=00", e); end
    if (bus.corr_count !== 8'd1) begin failures++; $display("FAIL sbe_reread_corr got=%0d exp=1", bus.corr_count); end
  endtask

  task automatic test_double_error();
    logic [10:0] d; logic [1:0] e; logic v1, v2;
    do_reset();
    host_write(4'd2, 11'h001, 16'h0003);
    for (int k = 0; k < 2; k++) begin
      host_read(4'd2, d, e, v1, v2);
      checks += 2;
      if (e !== 2'b10) begin failures++; $display("FAIL dbe_err%0d got=%b exp=10", k, e); end
      if (d !== 11'h001) begin failures++; $display("FAIL dbe_data%0d got=%h exp=001", k, d); end
    end
    checks += 3;
    if (bus.uncorr_count !== 8'd2) begin failures++; $display("FAIL dbe_uncorr got=%0d exp=2", bus.uncorr_count); end
    if (bus.corr_count !== 8'd0) begin failures++; $display("FAIL dbe_corr got=%0d exp=0", bus.corr_count); end
    if (dut.mem[2] !== 16'h000C) begin failures++; $display("FAIL dbe_no_writeback got=%h exp=000C", dut.mem[2]); end
  endtask

  task automatic test_scrub();
    logic [10:0] d; logic [1:0] e; logic v1, v2;
    do_reset();
    host_write(4'd5, 11'h5A5, 16'h0100);
    bus.scrub_en = 1'b1;
    repeat (200) @(posedge clk);
    #1 bus.scrub_en = 1'b0;
    checks += 2;
    if (bus.corr_count !== 8'd1) begin failures++; $display("FAIL scrub_corr got=%0d exp=1", bus.corr_count); end
    if (bus.uncorr_count !== 8'd0) begin failures++; $display("FAIL scrub_uncorr got=%0d exp=0", bus.uncorr_count); end
    host_read(4'd5, d, e, v1, v2);
    checks += 2;
    if (e !== 2'b00) begin failures++; $display("FAIL scrub_reread_err got=%b exp=00", e); end
    if (d !== 11'h5A5) begin failures++; $display("FAIL scrub_reread_data got=%h exp=5A5", d); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.scrub_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (dut.scrub_pending !== 1'b1) begin failures++; $display("FAIL prio_pending got=%b exp=1", dut.scrub_pending); end
    bus.scrub_en    = 1'b0;
    bus.wr_addr     = 4'd9;
    bus.wr_data     = 11'h123;
    bus.inject_mask = '0;
    bus.wr_req      = 1'b1;
    bus.rd_addr     = 4'd9;
    bus.rd_req      = 1'b1;
    @(posedge clk); #1 bus.wr_req = 1'b0;
    checks += 2;
    if (dut.state !== HOST_WR) begin failures++; $display("FAIL prio_first got=%0d exp=%0d", dut.state, HOST_WR); end
    if (bus.host_ready !== 1'b0) begin failures++; $display("FAIL prio_ready_wr got=%b exp=0", bus.host_ready); end
    @(posedge clk); #1;
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL prio_gap1 got=%0d exp=%0d", dut.state, IDLE); end
    @(posedge clk); #1 bus.rd_req = 1'b0;
    checks += 2;
    if (dut.state !== HOST_RD) begin failures++; $display("FAIL prio_second got=%0d exp=%0d", dut.state, HOST_RD); end
    if (bus.host_ready !== 1'b0) begin failures++; $display("FAIL prio_ready_rd got=%b exp=0", bus.host_ready); end
    @(posedge clk); #1;
    checks += 3;
    if (dut.state !== IDLE) begin failures++; $display("FAIL prio_gap2 got=%0d exp=%0d", dut.state, IDLE); end
    if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL prio_rd_valid got=%b exp=1", bus.rd_valid); end
    if (bus.rd_data !== 11'h123) begin failures++; $display("FAIL prio_rd_data got=%h exp=123", bus.rd_data); end
    @(posedge clk); #1;
    checks++;
    if (dut.state !== SCRUB_RD) begin failures++; $display("FAIL prio_third got=%0d exp=%0d", dut.state, SCRUB_RD); end
    @(posedge clk); #1;
    checks += 3;
    if (dut.state !== IDLE) begin failures++; $display("FAIL prio_done got=%0d exp=%0d", dut.state, IDLE); end
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL prio_scrub_no_valid got=%b exp=0", bus.rd_valid); end
    if (dut.scrub_ptr !== 4'd1) begin failures++; $display("FAIL prio_scrub_ptr got=%0d exp=1", dut.scrub_ptr); end
  endtask

  task automatic test_reset_writeback();
    logic [10:0] d; logic [1:0] e; logic v1, v2;
    do_reset();
    host_write(4'd7, 11'h3FF, 16'h0010);
    bus.rd_addr = 4'd7;
    bus.rd_req  = 1'b1;
    wait_ready("rst_wb_read");
    @(posedge clk); #1 bus.rd_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.state !== WRITEBACK) begin failures++; $display("FAIL rstwb_in_wb got=%0d exp=%0d", dut.state, WRITEBACK); end
    rst = 1'b1;
    #1;
    checks += 7;
    if (bus.host_ready !== 1'b1) begin failures++; $display("FAIL rstwb_ready got=%b exp=1", bus.host_ready); end
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rstwb_rd_valid got=%b exp=0", bus.rd_valid); end
    if (bus.rd_data !== 11'h000) begin failures++; $display("FAIL rstwb_rd_data got=%h exp=000", bus.rd_data); end
    if (bus.rd_err !== 2'b00) begin failures++; $display("FAIL rstwb_rd_err got=%b exp=00", bus.rd_err); end
    if (bus.corr_count !== 8'd0) begin failures++; $display("FAIL rstwb_corr got=%0d exp=0", bus.corr_count); end
    if (bus.uncorr_count !== 8'd0) begin failures++; $display("FAIL rstwb_uncorr got=%0d exp=0", bus.uncorr_count); end
    if (dut.mem[7] !== 16'h0000) begin failures++; $display("FAIL rstwb_mem got=%h exp=0000", dut.mem[7]); end
    @(posedge clk); #1 rst = 1'b0;
    host_read(4'd7, d, e, v1, v2);
    checks += 2;
    if (d !== 11'h000) begin failures++; $display("FAIL rstwb_read7_data got=%h exp=000", d); end
    if (e !== 2'b00) begin failures++; $display("FAIL rstwb_read7_err got=%b exp=00", e); end
    host_read(4'd15, d, e, v1, v2);
    checks += 2;
    if (d !== 11'h000) begin failures++; $display("FAIL rstwb_read15_data got=%h exp=000", d); end
    if (e !== 2'b00) begin failures++; $display("FAIL rstwb_read15_err got=%b exp=00", e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_single_error();
    test_double_error();
    test_scrub();
    test_priority();
    test_reset_writeback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
